// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// Module  : inst_fetch_queue_pkg
// Brief   : Shared widths, defaults and beat layout for the IF->ID fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

    localparam int IF_ID_LEN = 65;
    localparam int FQ_DEPTH  = 4;

    typedef struct packed {
        logic        ex_adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_beat_t;

    function automatic fq_beat_t fq_make_beat(input logic ex_adef, input logic [31:0] inst,
                                              input logic [31:0] pc);
        fq_beat_t b;
        b.ex_adef = ex_adef;
        b.inst    = inst;
        b.pc      = pc;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fq_mem.sv
// ============================================================================
// Module  : fq_mem
// Brief   : DEPTH x LEN register file, async clear, one write / one comb read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fq_mem
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int LEN   = IF_ID_LEN
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [LEN-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [LEN-1:0]           rdata
);

    logic [LEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module  : inst_fetch_queue
// Brief   : Circular IF->ID decoupling queue, flushed on exception/ertn/branch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int LEN   = IF_ID_LEN
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     IF_FQ_valid,
    input  logic [LEN-1:0]           IF_FQ_bus,
    output logic                     FQ_allowin,
    output logic                     FQ_ID_valid,
    output logic [LEN-1:0]           FQ_ID_bus,
    input  logic                     ID_allowin,
    input  logic                     WB_EXC_signal,
    input  logic                     WB_ERTN_signal,
    input  logic                     br_taken,
    output logic [$clog2(DEPTH):0]   FQ_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_enq;
    logic          w_deq;
    logic          w_flush;

    // Handshakes depend only on registered occupancy, never on the peers' inputs.
    assign FQ_allowin  = (r_count != c_full_count);
    assign FQ_ID_valid = (r_count != '0);
    assign FQ_count    = r_count;

    assign w_enq   = IF_FQ_valid & FQ_allowin;
    assign w_deq   = FQ_ID_valid & ID_allowin;
    assign w_flush = WB_EXC_signal | WB_ERTN_signal | br_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flushed beats must not land in storage; stale contents elsewhere are harmless.
    fq_mem #(
        .DEPTH (DEPTH),
        .LEN   (LEN)
    ) u_fq_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (w_enq & ~w_flush),
        .waddr  (r_wr_ptr),
        .wdata  (IF_FQ_bus),
        .raddr  (r_rd_ptr),
        .rdata  (FQ_ID_bus)
    );

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decoupling instruction queue between IF_stage and ID_stage. Stores up to DEPTH fetched beats of {ex_ADEF, inst, pc}. It lets IF keep issuing inst_sram requests while ID is stalled, which removes the need for IF to hold stalled instructions in its own buffer. Exception, ertn and taken-branch events flush the queue so no wrong-path instruction reaches ID.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- LEN, `IF_ID_LEN (65), beat width {ex_ADEF[64], inst[63:32], pc[31:0]}

Ports:
- clk  in  1  clock; single clock domain
- resetn  in  1  reset; asynchronous, active-low
- IF_FQ_valid  in  1  IF offers a beat this cycle
- IF_FQ_bus  in  LEN  beat from IF
- FQ_allowin  out  1  queue accepts a beat this cycle; drives IF's ID_allowin
- FQ_ID_valid  out  1  head entry valid
- FQ_ID_bus  out  LEN  head entry
- ID_allowin  in  1  ID consumes head this cycle
- WB_EXC_signal  in  1  flush request
- WB_ERTN_signal  in  1  flush request
- br_taken  in  1  flush request from ID; the branch instruction itself has already been dequeued
- FQ_count  out  clog2(DEPTH)+1  current occupancy

## Operation
- enq = IF_FQ_valid & FQ_allowin; deq = FQ_ID_valid & ID_allowin; flush = WB_EXC_signal | WB_ERTN_signal | br_taken.
- FQ_allowin = (count != DEPTH). It is registered-state only, with no combinational path from ID_allowin or IF_FQ_valid. A full queue refuses the beat even when a deq happens in the same cycle.
- FQ_ID_valid = (count != 0). FQ_ID_bus = mem[rd_ptr]. There is no bypass, so storage is read directly.
- Circular buffer:
  - wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - count is a separate register, clog2(DEPTH)+1 bits.
- Per edge, when flush = 0:
  - enq: mem[wr_ptr] ← IF_FQ_bus; wr_ptr+1.
  - deq: rd_ptr+1.
  - count ← count + enq − deq. Simultaneous enq and deq leaves count unchanged.
- Flush has priority over everything:
  - wr_ptr, rd_ptr and count ← 0.
  - The enq and deq of that cycle are discarded.
  - mem contents are left untouched.
- ex_ADEF is opaque payload and travels with its entry. The queue never interprets any field.
- Reset (async, resetn = 0):
  - ptrs and count ← 0.
  - All mem entries ← 0.
  - FQ_ID_valid = 0, FQ_ID_bus = 0, FQ_allowin = 1, FQ_count = 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-visible latency is 1 cycle. A beat enqueued at edge N is at FQ_ID_bus after edge N, when the queue was empty.
- Flush latency is 1 edge. After a flush edge, FQ_ID_valid = 0 and FQ_allowin = 1.
- A flush asserted for k consecutive cycles keeps the queue empty for all k cycles.
- Throughput is 1 beat/cycle in steady state while 0 < count < DEPTH.
- Full boundary:
  - Beats stay in FIFO order across pointer wrap-around.
  - count saturates at DEPTH by construction, because enq is blocked while full.
- Empty boundary: a deq is impossible while empty, since FQ_ID_valid = 0.

## Structure
- `IF_ID_LEN` lives in mycpu.h alongside the existing bus-length defines. Add `FQ_DEPTH` there as the default for DEPTH.
- Put the storage array in one sub-module, fq_mem. It is a DEPTH×LEN register file with an async-reset clear, a write port (we, waddr, wdata) and a combinational read port (raddr).
- Pointer, count and flush control stay in inst_fetch_queue.

## Test plan
- Reset, then 3 enqueues of pc 0x1C000000/04/08 with ID_allowin = 0 -> FQ_count = 3 and FQ_ID_bus.pc = 0x1C000000. Then ID_allowin = 1 -> pcs emerge in order, one per cycle.
- 4 enqueues with ID_allowin = 0 -> FQ_allowin = 0 at count 4. Hold IF_FQ_valid = 1 with pc 0x1C000010 -> that beat is not stored.
- Full queue, then ID_allowin = 1 and IF_FQ_valid = 1 in the same cycle -> only the deq occurs and count goes to 3. Next cycle FQ_allowin = 1.
- Wrap-around: stream 10 beats with a 1-cycle ID stall every 3rd cycle -> all 10 pcs out in order, no loss or duplicate.
- Fill 3 entries, then assert br_taken together with IF_FQ_valid = 1 and ID_allowin = 1 -> next cycle FQ_count = 0, FQ_ID_valid = 0, and the incoming beat is absent. Repeat with WB_EXC_signal and WB_ERTN_signal, same result.
- Fill 2 entries (one with ex_ADEF = 1 at pc 0x1C000002), then pulse resetn low between edges -> outputs go to their reset values immediately. After release, the first new beat is delivered correctly.
